// File: rtl/delay_line.sv
// Multi-lane programmable sample delay line: circular buffer with registered output.
// Optional build macro DELAY_LINE_ZERO_FILL_EN outputs zeros until the buffer holds D samples.
module delay_line #(
    parameter int unsigned DATAWIDTH = 16,
    parameter int unsigned CHANNELS  = 2,
    parameter int unsigned MAX_DELAY = 256,
    localparam int unsigned AW = $clog2(MAX_DELAY),
    localparam int unsigned BW = CHANNELS * DATAWIDTH
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          flush,
    input  logic [AW:0]   delay,
    input  logic          in_valid,
    input  logic [BW-1:0] data_in,
    output logic          out_valid,
    output logic [BW-1:0] data_out,
    output logic          primed
);

    localparam int unsigned DW = AW + 1;

    logic [BW-1:0] mem [MAX_DELAY];
    logic [AW-1:0] wp;
    logic [DW-1:0] fc;
    logic [DW-1:0] dly_eff;
    logic [AW-1:0] rd_addr;
    logic [BW-1:0] rd_data;

    // Clamp the requested delay into 1..MAX_DELAY
    always_comb begin
        dly_eff = delay;
        if (delay == '0) begin
            dly_eff = DW'(1);
        end else if (delay > DW'(MAX_DELAY)) begin
            dly_eff = DW'(MAX_DELAY);
        end
    end

    // At D = MAX_DELAY the low AW bits are zero, so the read hits wp before it is overwritten
    assign rd_addr = wp - dly_eff[AW-1:0];
    assign primed  = (fc >= dly_eff);

    always_comb begin
        rd_data = mem[rd_addr];
`ifdef DELAY_LINE_ZERO_FILL_EN
        if (fc < dly_eff) begin
            rd_data = '0;
        end
`endif
    end

    // Sample storage is deliberately left out of reset and flush
    always_ff @(posedge clock) begin
        if (in_valid && !flush) begin
            mem[wp] <= data_in;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wp        <= '0;
            fc        <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
        end else if (flush) begin
            wp        <= '0;
            fc        <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                data_out <= rd_data;
                wp       <= wp + AW'(1);
                if (fc != DW'(MAX_DELAY)) begin
                    fc <= fc + DW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_delay_line.sv
// Self-checking bench for delay_line: history-based scoreboard of expected delayed samples.
`timescale 1ns/1ps
module tb_delay_line;

    localparam int unsigned DATAWIDTH = 16;
    localparam int unsigned CHANNELS  = 2;
    localparam int unsigned MAX_DELAY = 256;
    localparam int unsigned AW        = $clog2(MAX_DELAY);
    localparam int unsigned DW        = AW + 1;
    localparam int unsigned BW        = CHANNELS * DATAWIDTH;
`ifdef DELAY_LINE_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic          clock;
    logic          reset_n;
    logic          flush;
    logic [DW-1:0] delay;
    logic          in_valid;
    logic [BW-1:0] data_in;
    logic          out_valid;
    logic [BW-1:0] data_out;
    logic          primed;

    delay_line #(
        .DATAWIDTH(DATAWIDTH),
        .CHANNELS (CHANNELS),
        .MAX_DELAY(MAX_DELAY)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (flush),
        .delay    (delay),
        .in_valid (in_valid),
        .data_in  (data_in),
        .out_valid(out_valid),
        .data_out (data_out),
        .primed   (primed)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic          ov;
        logic [BW-1:0] data;
        bit            known;
    } exp_t;

    exp_t          sb[$];
    logic [BW-1:0] hist[$];
    logic [BW-1:0] last_data;
    bit            last_known;
    int            passed;
    int            total;

    function automatic int clamp_d(input int d);
        if (d < 1) return 1;
        if (d > int'(MAX_DELAY)) return int'(MAX_DELAY);
        return d;
    endfunction

    function automatic bit exp_primed(input int d);
        int n;
        n = (hist.size() > int'(MAX_DELAY)) ? int'(MAX_DELAY) : hist.size();
        return n >= clamp_d(d);
    endfunction

    // Drive one cycle at the falling edge, queue the expectation, return just after the rising edge
    task automatic cyc(input bit v, input bit fl, input int dly, input logic [BW-1:0] d);
        exp_t e;
        int   dd;
        int   n;
        @(negedge clock);
        in_valid = v;
        flush    = fl;
        delay    = DW'(dly);
        data_in  = d;
        dd = clamp_d(dly);
        n  = hist.size();
        e.ov = v && !fl;
        if (fl) begin
            hist.delete();
            last_data  = '0;
            last_known = 1'b1;
        end else if (v) begin
            if (n >= dd) begin
                last_data  = hist[n-dd];
                last_known = 1'b1;
            end else if (ZF) begin
                last_data  = '0;
                last_known = 1'b1;
            end else begin
                last_known = 1'b0;
            end
            hist.push_back(d);
        end
        e.data  = last_data;
        e.known = last_known;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        delay    = DW'(4);
        data_in  = '0;
        repeat (2) @(negedge clock);
        total++;
        if (out_valid !== 1'b0) $display("FAIL reset_ov: got %0b want 0", out_valid);
        else passed++;
        total++;
        if (data_out !== '0) $display("FAIL reset_data: got %h want 0", data_out);
        else passed++;
        total++;
        if (primed !== 1'b0) $display("FAIL reset_primed: got %0b want 0", primed);
        else passed++;
        @(posedge clock);
        #2 reset_n = 1'b1;
        hist.delete();
        last_data  = '0;
        last_known = 1'b1;
    endtask

    task automatic test_ramp();
        exp_t e;
        for (int n = 1; n <= 12; n++) begin
            cyc(1'b1, 1'b0, 4, {DATAWIDTH'(n + 256), DATAWIDTH'(n)});
            e = sb.pop_front();
            total++;
            if (out_valid !== e.ov) $display("FAIL ramp_ov[%0d]: got %0b want %0b", n, out_valid, e.ov);
            else passed++;
            if (e.known) begin
                total++;
                if (data_out !== e.data) $display("FAIL ramp_data[%0d]: got %h want %h", n, data_out, e.data);
                else passed++;
            end
            total++;
            if (primed !== exp_primed(4)) $display("FAIL ramp_primed[%0d]: got %0b want %0b", n, primed, exp_primed(4));
            else passed++;
        end
    endtask

    task automatic test_clamp_wrap();
        exp_t e;
        int   dly;
        cyc(1'b1, 1'b1, 0, BW'($urandom));
        e = sb.pop_front();
        total++;
        if (out_valid !== 1'b0 || data_out !== '0) $display("FAIL clamp_flush: got %0b/%h want 0/0", out_valid, data_out);
        else passed++;
        for (int i = 0; i < 606; i++) begin
            if (i < 6) dly = 0;
            else if (i < 200) dly = 256;
            else if (i < 400) dly = 257;
            else dly = 511;
            cyc(1'b1, 1'b0, dly, BW'($urandom));
            e = sb.pop_front();
            total++;
            if (out_valid !== e.ov) $display("FAIL clamp_ov[%0d]: got %0b want %0b", i, out_valid, e.ov);
            else passed++;
            if (e.known) begin
                total++;
                if (data_out !== e.data) $display("FAIL clamp_data[%0d]: got %h want %h", i, data_out, e.data);
                else passed++;
            end
            if (i == 5 || i == 250 || i == 605) begin
                total++;
                if (primed !== exp_primed(dly)) $display("FAIL clamp_primed[%0d]: got %0b want %0b", i, primed, exp_primed(dly));
                else passed++;
            end
        end
    endtask

    task automatic test_delay_switch();
        exp_t e;
        cyc(1'b0, 1'b1, 8, '0);
        e = sb.pop_front();
        for (int i = 0; i < 30; i++) begin
            cyc(1'b1, 1'b0, (i < 20) ? 8 : 3, {DATAWIDTH'(1000 + i), DATAWIDTH'(i)});
            e = sb.pop_front();
            total++;
            if (out_valid !== e.ov) $display("FAIL switch_ov[%0d]: got %0b want %0b", i, out_valid, e.ov);
            else passed++;
            if (e.known) begin
                total++;
                if (data_out !== e.data) $display("FAIL switch_data[%0d]: got %h want %h", i, data_out, e.data);
                else passed++;
            end
        end
    endtask

    task automatic test_gaps();
        exp_t e;
        cyc(1'b0, 1'b1, 5, '0);
        e = sb.pop_front();
        for (int i = 0; i < 30; i++) begin
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                cyc(1'b0, 1'b0, 5, BW'($urandom));
                e = sb.pop_front();
                total++;
                if (out_valid !== 1'b0) $display("FAIL gap_ov[%0d]: got %0b want 0", i, out_valid);
                else passed++;
                if (e.known) begin
                    total++;
                    if (data_out !== e.data) $display("FAIL gap_hold[%0d]: got %h want %h", i, data_out, e.data);
                    else passed++;
                end
            end
            cyc(1'b1, (i == 10), 5, {DATAWIDTH'(2000 + i), DATAWIDTH'(i + 50)});
            e = sb.pop_front();
            total++;
            if (out_valid !== e.ov) $display("FAIL gaps_ov[%0d]: got %0b want %0b", i, out_valid, e.ov);
            else passed++;
            if (e.known) begin
                total++;
                if (data_out !== e.data) $display("FAIL gaps_data[%0d]: got %h want %h", i, data_out, e.data);
                else passed++;
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            if (i == 10) begin
                #2 reset_n = 1'b0;
                #1;
                total++;
                if (out_valid !== 1'b0 || data_out !== '0) $display("FAIL areset_now: got %0b/%h want 0/0", out_valid, data_out);
                else passed++;
                total++;
                if (primed !== 1'b0) $display("FAIL areset_primed: got %0b want 0", primed);
                else passed++;
                #1 reset_n = 1'b1;
                hist.delete();
                last_data  = '0;
                last_known = 1'b1;
            end
            cyc(1'b1, 1'b0, 2, {DATAWIDTH'(3000 + i), DATAWIDTH'(i + 90)});
            e = sb.pop_front();
            total++;
            if (out_valid !== e.ov) $display("FAIL areset_ov[%0d]: got %0b want %0b", i, out_valid, e.ov);
            else passed++;
            if (e.known) begin
                total++;
                if (data_out !== e.data) $display("FAIL areset_data[%0d]: got %h want %h", i, data_out, e.data);
                else passed++;
            end
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_ramp();
        test_clamp_wrap();
        test_delay_switch();
        test_gaps();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
